// File: rtl/puf_bit_packer.sv
// Integrates per-sample IQ magnitude over fixed windows and emits one response bit per window
// (1 when the window sum beats the previous one), packed LSB-first into AXI-Stream words.
// Define PUF_BIT_PACKER_MAXMIN_EN to use the max + min/2 magnitude estimate instead of |I| + |Q|.
module puf_bit_packer #(
  parameter int DATA_WIDTH    = 16,
  parameter int WIN_LEN       = 16,
  parameter int BITS_PER_WORD = 32,
  parameter int WORDS_PER_PKT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic                      in_tlast,
  input  logic [2*DATA_WIDTH-1:0]   in_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic                      out_tlast,
  output logic [BITS_PER_WORD-1:0]  out_tdata
);

  localparam int MW  = DATA_WIDTH + 1;
  localparam int SW  = $clog2(WIN_LEN);
  localparam int AW  = MW + SW;
  localparam int BCW = $clog2(BITS_PER_WORD + 1);
  localparam int BIW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WCW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Handshake rule: a beat moves on either side only in a cycle where valid and ready are both
  // high at the rising edge; the output word is held unchanged while out_tvalid & !out_tready.

  state_t                   state_q, state_n;
  logic [AW-1:0]            acc_q;
  logic [AW-1:0]            prev_q;
  logic                     prev_valid_q;
  logic [SW-1:0]            sample_cnt_q;
  logic [BCW-1:0]           bit_cnt_q;
  logic [WCW-1:0]           word_cnt_q;
  logic [BITS_PER_WORD-1:0] word_q;

  logic [DATA_WIDTH-1:0]    raw_i, raw_q;
  logic [DATA_WIDTH-1:0]    abs_i, abs_q;
  logic [MW-1:0]            mag;
  logic                     accept;
  logic                     win_end;
  logic [AW-1:0]            cur;
  logic [BITS_PER_WORD-1:0] word_n;
  logic [BCW-1:0]           bits_n;
  logic                     word_full;
  logic                     emit;
  logic                     emit_last;

  assign in_tready = !out_tvalid || out_tready;

  // Two's-complement absolute value; the most negative input maps to 2^(DW-1), which still fits.
  always_comb begin
    raw_i = in_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    raw_q = in_tdata[DATA_WIDTH-1:0];
    abs_i = raw_i[DATA_WIDTH-1] ? (~raw_i + DATA_WIDTH'(1)) : raw_i;
    abs_q = raw_q[DATA_WIDTH-1] ? (~raw_q + DATA_WIDTH'(1)) : raw_q;
  end

`ifdef PUF_BIT_PACKER_MAXMIN_EN
  logic [DATA_WIDTH-1:0] max_v, min_v;
  always_comb begin
    max_v = (abs_i >= abs_q) ? abs_i : abs_q;
    min_v = (abs_i >= abs_q) ? abs_q : abs_i;
    mag   = {1'b0, max_v} + {2'b00, min_v[DATA_WIDTH-1:1]};
  end
`else
  always_comb begin
    mag = {1'b0, abs_i} + {1'b0, abs_q};
  end
`endif

  always_comb begin
    accept    = in_tvalid && in_tready;
    win_end   = (sample_cnt_q == SW'(WIN_LEN - 1));
    cur       = acc_q + AW'(mag);
    word_n    = word_q;
    bits_n    = bit_cnt_q;
    if (win_end && prev_valid_q) begin
      word_n[bit_cnt_q[BIW-1:0]] = (cur > prev_q);
      bits_n                     = bit_cnt_q + BCW'(1);
    end
    word_full = (bits_n == BCW'(BITS_PER_WORD));
    // A frame end flushes any partial word; a word that fills up on that same sample goes out normally.
    emit      = accept && (word_full || (in_tlast && (bits_n != '0)));
    emit_last = word_full ? (word_cnt_q == WCW'(WORDS_PER_PKT - 1)) : 1'b1;
  end

  always_comb begin
    state_n = state_q;
    if (accept) begin
      state_n = in_tlast ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
    end else if (accept) begin
      if (win_end) begin
        prev_q <= cur;
      end
      if (in_tlast) begin
        acc_q        <= '0;
        sample_cnt_q <= '0;
        prev_valid_q <= 1'b0;
        bit_cnt_q    <= '0;
        word_cnt_q   <= '0;
        word_q       <= '0;
      end else if (win_end) begin
        acc_q        <= '0;
        sample_cnt_q <= '0;
        prev_valid_q <= 1'b1;
        if (word_full) begin
          bit_cnt_q  <= '0;
          word_q     <= '0;
          word_cnt_q <= (word_cnt_q == WCW'(WORDS_PER_PKT - 1)) ? '0 : word_cnt_q + WCW'(1);
        end else begin
          bit_cnt_q  <= bits_n;
          word_q     <= word_n;
        end
      end else begin
        acc_q        <= cur;
        sample_cnt_q <= sample_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
    end else if (emit) begin
      out_tvalid <= 1'b1;
      out_tlast  <= emit_last;
      out_tdata  <= word_n;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_bit_packer.sv
// Randomized and directed bench for puf_bit_packer: a window-sum reference model feeds an
// expected-word queue that is compared against every output transfer.
module tb_puf_bit_packer;

  localparam int DW  = 16;
  localparam int WL  = 4;
  localparam int BPW = 8;
  localparam int WPP = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_tvalid;
  logic            in_tready;
  logic            in_tlast;
  logic [2*DW-1:0] in_tdata;
  logic            out_tvalid;
  logic            out_tready;
  logic            out_tlast;
  logic [BPW-1:0]  out_tdata;

  logic [BPW:0]    exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              n_words = 0;
  logic [BPW-1:0]  last_word;
  logic            last_tlast;
  bit              rand_phase;

  longint          m_sum, m_prev;
  int              m_cnt, m_pkt;
  bit              m_have_prev;
  bit              m_bits[$];

  puf_bit_packer #(
    .DATA_WIDTH(DW), .WIN_LEN(WL), .BITS_PER_WORD(BPW), .WORDS_PER_PKT(WPP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast), .in_tdata(in_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast), .out_tdata(out_tdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: window sums compared with plain integer arithmetic
  function automatic longint mag(input int i, input int q);
    longint ai, aq;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
`ifdef PUF_BIT_PACKER_MAXMIN_EN
    if (ai >= aq) return ai + aq / 2;
    else          return aq + ai / 2;
`else
    return ai + aq;
`endif
  endfunction

  task automatic model_reset();
    m_sum = 0; m_prev = 0; m_cnt = 0; m_pkt = 0; m_have_prev = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  task automatic model_flush(input bit last);
    logic [BPW-1:0] w;
    w = '0;
    foreach (m_bits[k]) w[k] = m_bits[k];
    exp_q.push_back({last, w});
    m_bits.delete();
  endtask

  task automatic model_accept(input int i, input int q, input bit last);
    m_sum += mag(i, q);
    m_cnt++;
    if (m_cnt == WL) begin
      if (m_have_prev) m_bits.push_back(m_sum > m_prev);
      m_prev = m_sum;
      m_have_prev = 1;
      m_sum = 0;
      m_cnt = 0;
    end
    if (m_bits.size() == BPW) begin
      m_pkt++;
      model_flush(m_pkt == WPP);
      if (m_pkt == WPP) m_pkt = 0;
    end
    if (last) begin
      if (m_bits.size() > 0) model_flush(1'b1);
      m_sum = 0; m_cnt = 0; m_have_prev = 0; m_pkt = 0;
    end
  endtask

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic send(input int i, input int q, input bit last);
    bit acc;
    int tries;
    in_tvalid = 1'b1;
    in_tdata  = {16'(i), 16'(q)};
    in_tlast  = last;
    tries = 0;
    acc = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_tready;
      if (acc) model_accept(i, q, last);
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check("in_tready_timeout", in_tready, 1);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_window(input int i, input int q, input bit last);
    for (int s = 0; s < WL; s++) send(i, q, last && (s == WL - 1));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_exp_q_size", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_words = 0;
  endtask

  // scoreboard: every output transfer is matched against the model queue
  always @(negedge clk) begin
    if (!reset && out_tvalid && out_tready) begin
      logic [BPW:0] e;
      n_words++;
      last_word  = out_tdata;
      last_tlast = out_tlast;
      check("word_expected_by_model", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_tdata", out_tdata, e[BPW-1:0]);
        check("out_tlast", out_tlast, e[BPW]);
      end
    end
  end

  initial begin
    reset = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0; out_tready = 1'b1;
    rand_phase = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_out_tlast", out_tlast, 0);
    check("rst_out_tdata", out_tdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_tready", in_tready, 1);
    @(posedge clk); #1;

    // nine rising windows -> one full word of ones
    n_words = 0;
    for (int k = 0; k < 9; k++) send_window(100 * (k + 1), 0, 0);
    drain();
    check("rise_words", n_words, 1);
    check("rise_word", last_word, 8'hFF);
    check("rise_tlast", last_tlast, 0);

    // alternating amplitude -> 0xAA twice, second closes the packet
    do_reset();
    for (int k = 0; k < 17; k++) send_window((k % 2 == 0) ? 500 : 100, 0, 0);
    drain();
    check("alt_words", n_words, 2);
    check("alt_word", last_word, 8'hAA);
    check("alt_tlast", last_tlast, 1);

    // frame end flushes partial word; following frame restarts comparison
    do_reset();
    for (int k = 0; k < 4; k++) send_window(100 * (k + 1), 0, k == 3);
    drain();
    check("tlast_words", n_words, 1);
    check("tlast_word", last_word, 8'h07);
    check("tlast_tlast", last_tlast, 1);
    n_words = 0;
    for (int k = 0; k < 9; k++) send_window(100 * (k + 1), 0, 0);
    drain();
    check("newframe_words", n_words, 1);
    check("newframe_word", last_word, 8'hFF);
    check("newframe_tlast", last_tlast, 0);

    // backpressure: pending word holds and stalls the input
    do_reset();
    out_tready = 1'b0;
    for (int k = 0; k < 9; k++) send_window(100 * (k + 1), 0, 0);
    @(negedge clk);
    check("bp_out_tvalid", out_tvalid, 1);
    check("bp_in_tready", in_tready, 0);
    check("bp_out_tdata", out_tdata, 8'hFF);
    repeat (3) @(negedge clk);
    check("bp_hold_tdata", out_tdata, 8'hFF);
    check("bp_hold_tvalid", out_tvalid, 1);
    @(posedge clk); #1;
    out_tready = 1'b1;
    @(negedge clk);
    check("bp_release_in_tready", in_tready, 1);
    @(posedge clk); #1;
    drain();
    check("bp_words", n_words, 1);

    // full-scale magnitudes: B, A, B windows -> bits 1,0
    do_reset();
    send_window(32767, 32767, 0);
    send_window(-32768, -32768, 0);
    send_window(32767, 32767, 1);
    drain();
    check("ext_word", last_word, 8'h01);
    check("ext_tlast", last_tlast, 1);
    // equal sums yield 0
    send_window(100, 0, 0);
    send_window(0, 100, 1);
    drain();
    check("eq_word", last_word, 8'h00);
    check("eq_tlast", last_tlast, 1);

    // asynchronous reset mid-window with five bits collected
    do_reset();
    for (int k = 0; k < 6; k++) send_window(100 * (k + 1), 0, 0);
    send(700, 0, 0);
    send(700, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_out_tvalid", out_tvalid, 0);
    check("midrst_out_tlast", out_tlast, 0);
    check("midrst_out_tdata", out_tdata, 0);
    check("midrst_in_tready", in_tready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    n_words = 0;
    for (int k = 0; k < 9; k++) send_window(100 * (k + 1), 0, 0);
    drain();
    check("midrst_words", n_words, 1);
    check("midrst_word", last_word, 8'hFF);
    check("midrst_tlast", last_tlast, 0);

    // randomized traffic with gaps, frame ends and backpressure
    do_reset();
    rand_phase = 1;
    fork
      begin
        for (int n = 0; n < 600; n++) begin
          int i, q;
          if ($urandom_range(0, 9) == 0) begin
            i = $urandom_range(0, 65535) - 32768;
            q = $urandom_range(0, 65535) - 32768;
          end else begin
            i = $urandom_range(0, 6) - 3;
            q = $urandom_range(0, 6) - 3;
          end
          send(i, q, $urandom_range(0, 39) == 0);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_phase = 0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          out_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_tready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/puf_bit_packer.md
# puf_bit_packer

Downstream consumer of the interpolated IQ stream produced by the linear-interpolation PUF front end. Computes a per-sample magnitude, integrates it over fixed windows, and emits one response bit per window: 1 if the window sum exceeds the previous window sum. Bits are packed into words and framed into AXI-Stream packets for the PUF response path.

## Interface
- DATA_WIDTH, 16, width of each I/Q component (signed, two's complement)
- WIN_LEN, 16, samples per integration window; power of two, >= 2
- BITS_PER_WORD, 32, response bits per output word; output width
- WORDS_PER_PKT, 4, words per output packet (out_tlast period)

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_tvalid  in  1  input sample valid
- in_tready  out  1  input sample accepted when in_tvalid & in_tready
- in_tlast  in  1  last sample of input frame
- in_tdata  in  2*DATA_WIDTH  {I[2*DW-1:DW], Q[DW-1:0]}
- out_tvalid  out  1  output word valid
- out_tready  in  1  downstream ready
- out_tlast  out  1  last word of packet
- out_tdata  out  BITS_PER_WORD  packed response bits

## Operation
- Magnitude per accepted sample: m = |I| + |Q|, unsigned, DATA_WIDTH+1 bits; |-2^(DW-1)| = 2^(DW-1), no saturation needed.
- Accumulator: DATA_WIDTH+1+log2(WIN_LEN) bits, never overflows. Sample counter 0..WIN_LEN-1 wraps.
- On the sample that completes a window: cur = acc + m; accumulator cleared.
  - If prev_valid: bit = (cur > prev) strictly; equal yields 0. Bit shifted into word at position bit_cnt (LSB first).
  - If !prev_valid: no bit; prev_valid <= 1.
  - prev <= cur in both cases.
- When bit_cnt reaches BITS_PER_WORD: word loaded into output register, out_tvalid=1, bit_cnt=0, word_cnt increments; out_tlast=1 when word_cnt == WORDS_PER_PKT-1, then word_cnt wraps to 0.
- in_tlast accepted: the sample is processed into the accumulator, then the partial window (even if complete on this sample, its bit is still emitted first) is discarded; acc, sample counter, prev_valid cleared. If bit_cnt>0, the partial word is emitted zero-padded in upper bits with out_tlast=1. If bit_cnt==0 and word_cnt>0, no extra word; word_cnt cleared (packet ends short, untagged). word_cnt cleared in all cases.
- State machine: IDLE (no window started) -> ACCUM (counting samples) -> ACCUM on window end; any state -> IDLE on in_tlast or reset.

## Timing
- Reset values: in_tready=1 after reset deassertion, out_tvalid=0, out_tlast=0, out_tdata=0; all counters, acc, prev, prev_valid = 0.
- Reset asserted mid-operation: all state cleared immediately; pending output word lost.
- Single output register. in_tready = !out_tvalid | out_tready (combinational).
- Latency: word visible on out_tvalid the cycle after acceptance of the completing sample.
- out_tdata/out_tlast held stable while out_tvalid & !out_tready.
- Back-to-back: full throughput (one sample per cycle) when out_tready held high.
- in_tvalid low: no state change (windows span gaps).

## Configuration
- PUF_BIT_PACKER_MAXMIN_EN defined: m = max(|I|,|Q|) + (min(|I|,|Q|) >> 1), still DATA_WIDTH+1 bits.
- Undefined: m = |I| + |Q|.
- All other behaviour identical.

## Test plan
Bench parameters: DATA_WIDTH=16, WIN_LEN=4, BITS_PER_WORD=8, WORDS_PER_PKT=2, out_tready=1 unless stated.
- 9 windows, window k all samples I=100*(k+1), Q=0 -> one word 0xFF, out_tlast=0.
- 17 windows alternating I=500 / I=100 (Q=0), starting with 500 -> bits 0,1,0,1...; words 0xAA, 0xAA, second with out_tlast=1.
- 4 windows increasing amplitude, in_tlast on last sample of window 4 -> one word 0x07 with out_tlast=1; next frame first window emits no bit.
- out_tready=0 while a word is pending -> in_tready=0, out_tdata stable; release -> word transfers, in_tready=1 same cycle.
- Samples I=-32768, Q=-32768 vs I=32767, Q=32767 windows -> magnitudes 65536 vs 65534, bit 0; with PUF_BIT_PACKER_MAXMIN_EN, 49152 vs 49150, bit 0.
- Reset asserted mid-window with bit_cnt=5 -> outputs at reset values next edge; no partial word emitted.
